dot_product_package_feeder: RTL and testbench

Upstream stage of the 8-wide dot-product engine. Accepts two element-serial operand streams (matrix row and vector) over a valid/ready handshake and packs them into `no_of_units`-element packages. Presents each package to the engine with a one-cycle `read_now` strobe, then captures the scalar result when the engine reports finish. A two-entry buffer (fill register plus output register) lets the next package be collected while the current one is held for the engine.

---
 rtl/dot_product_package_feeder.sv | 198 +++++++++++++++++++
 tb/tb_dot_product_package_feeder.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_package_feeder.sv
// Packs element-serial row/vector pairs into no_of_units packages for the dot-product engine, then captures its result (zero padding under FEEDER_ZERO_PAD_EN).
// Latency: read_now one cycle after a package's last element is accepted if the output register is free; result_valid one cycle after dp_finish rises.
// Backpressure: in_ready drops while the fill register is full and the output register is still inside its hold window.
module dot_product_package_feeder #(
  parameter int element_width = 32,
  parameter int no_of_units   = 8,
  parameter int issue_gap     = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [31:0]                          total,
  input  logic [element_width-1:0]             a_in,
  input  logic [element_width-1:0]             b_in,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [element_width*no_of_units-1:0] first_row_output,
  output logic [element_width*no_of_units-1:0] second_row_output,
  output logic                                 read_now,
  output logic [31:0]                          total_out,
  input  logic                                 dp_finish,
  input  logic [element_width-1:0]             dp_result,
  output logic [element_width-1:0]             result,
  output logic                                 result_valid,
  output logic                                 busy,
  output logic                                 error
);

  localparam int PW = element_width * no_of_units;
  localparam int CW = (no_of_units > 1) ? $clog2(no_of_units) : 1;
  localparam int HW = (issue_gap > 0) ? $clog2(issue_gap + 1) : 1;
  localparam logic [CW-1:0] LAST_SLOT = CW'(no_of_units - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(issue_gap);
  localparam logic [32:0]   UNITS33   = 33'(no_of_units);
`ifdef FEEDER_ZERO_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STREAM   = 2'd1,
    DRAIN    = 2'd2,
    WAIT_FIN = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Operation bookkeeping
  logic [31:0]   total_r;      // element count requested by start
  logic [31:0]   pkg_total;    // packages in this dot product
  logic [31:0]   elem_cnt;     // pairs accepted so far
  logic [31:0]   pkgs_issued;  // packages moved to the output register
  // Fill register (first buffer entry)
  logic [PW-1:0] fill_a, fill_b;
  logic [CW-1:0] fill_cnt;
  logic          fill_full;
  // Output register hold window, cycles left after the current one
  logic [HW-1:0] hold_cnt;
  logic          dp_finish_q;

  // Combinational datapath controls
  logic          total_ok, start_ok;
  logic [32:0]   pkg_calc;
  logic          out_free, accept, last_elem, pkg_done, xfer, fin_rise;
  logic [PW-1:0] merged_a, merged_b;
  int            slot_lo;

  // Handshake, package completion, transfer and merged fill contents.
  always_comb begin
    total_ok  = (total != 32'd0) && (PAD_EN || ((total % 32'(no_of_units)) == 32'd0));
    start_ok  = start && (state == IDLE) && total_ok;
    pkg_calc  = ({1'b0, total} + UNITS33 - 33'd1) / UNITS33;

    out_free  = (hold_cnt == '0);
    // A full fill register can only take a new element when it empties this cycle.
    in_ready  = (state == STREAM) && (!fill_full || out_free);
    accept    = in_valid && in_ready;
    last_elem = (elem_cnt == (total_r - 32'd1));
    pkg_done  = accept && ((fill_cnt == LAST_SLOT) || last_elem);
    xfer      = ((state == STREAM) || (state == DRAIN)) && out_free && (fill_full || pkg_done);
    fin_rise  = (state == WAIT_FIN) && dp_finish && !dp_finish_q;

    // Element k of a package goes MSB-first; a full fill register is being
    // emptied whenever an element is accepted, so the new one starts from zero.
    merged_a  = fill_full ? '0 : fill_a;
    merged_b  = fill_full ? '0 : fill_b;
    slot_lo   = element_width * (no_of_units - 1 - int'(fill_cnt));
    merged_a[slot_lo +: element_width] = a_in;
    merged_b[slot_lo +: element_width] = b_in;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    case (state)
      IDLE:     if (start_ok) state_nxt = STREAM;
      STREAM:   if (accept && last_elem) state_nxt = DRAIN;
      // Leave only once the last package has sat out its full hold window.
      DRAIN:    if ((pkgs_issued == pkg_total) && out_free && !read_now) state_nxt = WAIT_FIN;
      WAIT_FIN: if (fin_rise) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Datapath: start bookkeeping, fill register, output register, result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      total_r           <= '0;
      pkg_total         <= '0;
      elem_cnt          <= '0;
      pkgs_issued       <= '0;
      fill_a            <= '0;
      fill_b            <= '0;
      fill_cnt          <= '0;
      fill_full         <= 1'b0;
      hold_cnt          <= '0;
      dp_finish_q       <= 1'b0;
      first_row_output  <= '0;
      second_row_output <= '0;
      read_now          <= 1'b0;
      total_out         <= '0;
      result            <= '0;
      result_valid      <= 1'b0;
      error             <= 1'b0;
    end else begin
      dp_finish_q  <= dp_finish;
      read_now     <= 1'b0;
      result_valid <= 1'b0;
      if (hold_cnt != '0) hold_cnt <= hold_cnt - HW'(1);

      if (start) begin
        if (start_ok) begin
          error       <= 1'b0;
          total_r     <= total;
          pkg_total   <= pkg_calc[31:0];
          total_out   <= 32'(pkg_calc * UNITS33);
          elem_cnt    <= '0;
          pkgs_issued <= '0;
          fill_cnt    <= '0;
          fill_full   <= 1'b0;
          fill_a      <= '0;
          fill_b      <= '0;
        end else begin
          error <= 1'b1;
        end
      end

      if (accept) begin
        elem_cnt <= elem_cnt + 32'd1;
        if (pkg_done) begin
          fill_cnt <= '0;
          if (xfer && !fill_full) begin
            // Completed package bypasses straight into the output register.
            fill_a    <= '0;
            fill_b    <= '0;
            fill_full <= 1'b0;
          end else begin
            fill_a    <= merged_a;
            fill_b    <= merged_b;
            fill_full <= 1'b1;
          end
        end else begin
          fill_cnt  <= fill_cnt + CW'(1);
          fill_a    <= merged_a;
          fill_b    <= merged_b;
          fill_full <= 1'b0;
        end
      end else if (xfer) begin
        fill_a    <= '0;
        fill_b    <= '0;
        fill_full <= 1'b0;
      end

      if (xfer) begin
        first_row_output  <= fill_full ? fill_a : merged_a;
        second_row_output <= fill_full ? fill_b : merged_b;
        read_now          <= 1'b1;
        hold_cnt          <= HOLD_INIT;
        pkgs_issued       <= pkgs_issued + 32'd1;
      end

      if (fin_rise) begin
        result       <= dp_result;
        result_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dot_product_package_feeder.sv
module tb_dot_product_package_feeder;
  localparam int W  = 32;
  localparam int N  = 8;
  localparam int G  = 10;
  localparam int PW = W * N;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   total = '0;
  logic [W-1:0]  a_in = '0;
  logic [W-1:0]  b_in = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] first_row_output;
  logic [PW-1:0] second_row_output;
  logic          read_now;
  logic [31:0]   total_out;
  logic          dp_finish = 1'b0;
  logic [W-1:0]  dp_result = '0;
  logic [W-1:0]  result;
  logic          result_valid;
  logic          busy;
  logic          error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Observations
  logic [PW-1:0] pkg_a[$];
  logic [PW-1:0] pkg_b[$];
  int            pkg_cyc[$];
  logic [W-1:0]  exp_a[$];
  logic [W-1:0]  exp_b[$];
  int            acc_cyc[$];
  int            rv_cnt = 0;
  int            rv_cyc = 0;
  int            hold_viol = 0;
  int            last_rn = -1000;
  int            stall_cnt = 0;
  logic [PW-1:0] prev_a = '0;
  logic [PW-1:0] prev_b = '0;

  dot_product_package_feeder #(
    .element_width(W),
    .no_of_units(N),
    .issue_gap(G)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .total(total),
    .a_in(a_in),
    .b_in(b_in),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .first_row_output(first_row_output),
    .second_row_output(second_row_output),
    .read_now(read_now),
    .total_out(total_out),
    .dp_finish(dp_finish),
    .dp_result(dp_result),
    .result(result),
    .result_valid(result_valid),
    .busy(busy),
    .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Engine-side monitor: package captures, hold-window stability, result pulses.
  always @(negedge clk) begin
    if (read_now) begin
      pkg_a.push_back(first_row_output);
      pkg_b.push_back(second_row_output);
      pkg_cyc.push_back(cyc);
      last_rn = cyc;
    end else if (reset && (cyc - last_rn) <= G &&
                 (first_row_output !== prev_a || second_row_output !== prev_b)) begin
      hold_viol++;
    end
    prev_a = first_row_output;
    prev_b = second_row_output;
    if (result_valid) begin
      rv_cnt++;
      rv_cyc = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Small positive integer to IEEE-754 single.
  function automatic logic [31:0] f32(input int v);
    int e;
    logic [31:0] m;
    e = 0;
    while ((v >> (e + 1)) != 0) e++;
    m = 32'(v - (1 << e)) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  task automatic do_start(input logic [31:0] t);
    pkg_a.delete(); pkg_b.delete(); pkg_cyc.delete();
    exp_a.delete(); exp_b.delete(); acc_cyc.delete();
    rv_cnt = 0; hold_viol = 0; stall_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1;
    total = t;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: valid always high, 1: toggling, 2: random
  task automatic drive_stream(input int n, input int mode, input bit use_float);
    int i;
    int guard;
    logic [W-1:0] cur_a, cur_b;
    i = 0;
    guard = 0;
    cur_a = use_float ? f32(1) : W'($urandom);
    cur_b = use_float ? 32'h3F80_0000 : W'($urandom);
    while (i < n && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = ((guard % 2) == 1);
        default: in_valid = ($urandom_range(0, 3) != 0);
      endcase
      a_in = cur_a;
      b_in = cur_b;
      @(negedge clk);
      if (in_valid && !in_ready) stall_cnt++;
      if (in_valid && in_ready) begin
        exp_a.push_back(a_in);
        exp_b.push_back(b_in);
        acc_cyc.push_back(cyc);
        i++;
        cur_a = use_float ? f32(i + 1) : W'($urandom);
        cur_b = use_float ? 32'h3F80_0000 : W'($urandom);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (i != n) begin
      errors++;
      $display("FAIL stream_accept_timeout accepted=%0d required=%0d", i, n);
    end
  endtask

  task automatic run_op(input int n, input int mode, input bit use_float, input bit early_fin,
                        input logic [W-1:0] res);
    int npk, guard, fc, last_idx, exp_issue;
    logic [PW-1:0] ea, eb;
    npk = (n + N - 1) / N;
    if (early_fin) dp_finish = 1'b1;
    checks++;
    if (total_out !== 32'(npk * N)) begin
      errors++;
      $display("FAIL total_out got=%0d exp=%0d", total_out, npk * N);
    end
    drive_stream(n, mode, use_float);
    guard = 0;
    while (pkg_a.size() < npk && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    repeat (G + 5) @(posedge clk);
    #1;
    checks++;
    if (pkg_a.size() != npk) begin
      errors++;
      $display("FAIL pkg_count got=%0d exp=%0d", pkg_a.size(), npk);
    end
    for (int p = 0; p < npk && p < pkg_a.size(); p++) begin
      ea = '0;
      eb = '0;
      for (int k = 0; k < N; k++) begin
        if (p * N + k < exp_a.size()) begin
          ea[W*(N-k)-1 -: W] = exp_a[p*N+k];
          eb[W*(N-k)-1 -: W] = exp_b[p*N+k];
        end
      end
      checks++;
      if (pkg_a[p] !== ea || pkg_b[p] !== eb) begin
        errors++;
        $display("FAIL pkg_data[%0d] row got=%h exp=%h vec got=%h exp=%h", p, pkg_a[p], ea, pkg_b[p], eb);
      end
      // Issue when the last element is in and the previous package's window is over.
      last_idx = (((p + 1) * N < n) ? (p + 1) * N : n) - 1;
      exp_issue = (last_idx < acc_cyc.size()) ? acc_cyc[last_idx] + 1 : -1;
      if (p > 0 && pkg_cyc[p-1] + G + 1 > exp_issue) exp_issue = pkg_cyc[p-1] + G + 1;
      checks++;
      if (pkg_cyc[p] != exp_issue) begin
        errors++;
        $display("FAIL pkg_issue_cycle[%0d] got=%0d exp=%0d", p, pkg_cyc[p], exp_issue);
      end
    end
    checks++;
    if (hold_viol != 0) begin
      errors++;
      $display("FAIL hold_window_changes got=%0d exp=0", hold_viol);
    end
    if (early_fin) begin
      checks++;
      if (rv_cnt != 0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL early_finish_ignored result_valid_pulses=%0d busy=%0b exp 0/1", rv_cnt, busy);
      end
      @(posedge clk); #1;
      dp_finish = 1'b0;
    end
    @(posedge clk); #1;
    dp_result = res;
    dp_finish = 1'b1;
    fc = cyc;
    @(posedge clk); #1;
    dp_finish = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rv_cnt != 1 || rv_cyc != fc + 1) begin
      errors++;
      $display("FAIL result_valid pulses=%0d at=%0d exp 1 at %0d", rv_cnt, rv_cyc, fc + 1);
    end
    checks++;
    if (result !== res) begin
      errors++;
      $display("FAIL result got=%h exp=%h", result, res);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_finish got=%0b exp=0", busy);
    end
  endtask

  task automatic check_all_reset(input string tag);
    checks++;
    if ({in_ready, read_now, result_valid, busy, error} !== 5'b0) begin
      errors++;
      $display("FAIL %s_flags got=%b exp=00000", tag, {in_ready, read_now, result_valid, busy, error});
    end
    checks++;
    if (first_row_output !== '0 || second_row_output !== '0 || result !== '0 || total_out !== '0) begin
      errors++;
      $display("FAIL %s_data row=%h vec=%h result=%h total_out=%0d exp all 0", tag,
               first_row_output, second_row_output, result, total_out);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    check_all_reset("reset_held");
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_reset("reset_released");
  endtask

  task automatic test_float16;
    logic [PW-1:0] p0;
    do_start(16);
    run_op(16, 0, 1'b1, 1'b0, 32'h4308_0000);
    p0 = (pkg_a.size() > 0) ? pkg_a[0] : '0;
    checks++;
    if (p0[PW-1 -: W] !== 32'h3F80_0000) begin
      errors++;
      $display("FAIL float16_first_slot got=%h exp=3f800000", p0[PW-1 -: W]);
    end
  endtask

  task automatic test_back_to_back;
    do_start(24);
    run_op(24, 0, 1'b0, 1'b1, W'($urandom));
    checks++;
    if (stall_cnt == 0) begin
      errors++;
      $display("FAIL back_to_back_stall in_ready_low_cycles=%0d exp >0", stall_cnt);
    end
  endtask

  task automatic test_toggle;
    do_start(8);
    run_op(8, 1, 1'b0, 1'b0, W'($urandom));
    checks++;
    if (pkg_cyc.size() != 1 || acc_cyc.size() != 8 || pkg_cyc[0] != acc_cyc[7] + 1) begin
      errors++;
      $display("FAIL toggle_latency issue=%0d exp=%0d", (pkg_cyc.size() > 0) ? pkg_cyc[0] : -1,
               (acc_cyc.size() == 8) ? acc_cyc[7] + 1 : -1);
    end
  endtask

  task automatic test_error;
    do_start(0);
    checks++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_total error=%0b busy=%0b exp 1/0", error, busy);
    end
    do_start(16);
    checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL valid_start_clears error=%0b busy=%0b exp 0/1", error, busy);
    end
    do_start(8);
    checks++;
    if (error !== 1'b1 || busy !== 1'b1 || total_out !== 32'd16) begin
      errors++;
      $display("FAIL start_while_busy error=%0b busy=%0b total_out=%0d exp 1/1/16", error, busy, total_out);
    end
    run_op(16, 2, 1'b0, 1'b0, W'($urandom));
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL error_sticky got=%0b exp=1", error);
    end
  endtask

  task automatic test_partial;
    do_start(12);
`ifdef FEEDER_ZERO_PAD_EN
    run_op(12, 2, 1'b0, 1'b0, W'($urandom));
`else
    checks++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL partial_rejected error=%0b busy=%0b exp 1/0", error, busy);
    end
`endif
  endtask

  task automatic test_reset_mid;
    int seen_rdy;
    do_start(16);
    drive_stream(5, 0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_all_reset("reset_mid");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    seen_rdy = 0;
    in_valid = 1'b1;
    repeat (30) begin
      @(posedge clk); #1;
      a_in = W'($urandom);
      b_in = W'($urandom);
      @(negedge clk);
      if (in_ready) seen_rdy++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (pkg_a.size() != 0 || seen_rdy != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_quiet packages=%0d ready_cycles=%0d busy=%0b exp 0/0/0",
               pkg_a.size(), seen_rdy, busy);
    end
  endtask

  task automatic test_random;
    int n;
    for (int r = 0; r < 3; r++) begin
`ifdef FEEDER_ZERO_PAD_EN
      n = int'($urandom_range(1, 40));
`else
      n = N * int'($urandom_range(1, 5));
`endif
      do_start(32'(n));
      run_op(n, 2, 1'b0, 1'b0, W'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_float16();
    test_back_to_back();
    test_toggle();
    test_error();
    test_partial();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
